// File: rtl/xalu_pkg.sv
// Shared op codes, op classification helpers and queue payload for the XALU issue stage.
package xalu_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
    localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
    localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
    localparam logic [OP_W-1:0] OP_MADD  = 4'd5;
    localparam logic [OP_W-1:0] OP_MADDU = 4'd6;
    localparam logic [OP_W-1:0] OP_MSUB  = 4'd7;
    localparam logic [OP_W-1:0] OP_MSUBU = 4'd8;
    localparam logic [OP_W-1:0] OP_MTHI  = 4'd9;
    localparam logic [OP_W-1:0] OP_MTLO  = 4'd10;
    localparam logic [OP_W-1:0] OP_MFHI  = 4'd11;
    localparam logic [OP_W-1:0] OP_MFLO  = 4'd12;

    localparam int unsigned MUL_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF = 10;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } md_op_t;

    function automatic logic is_arith(input logic [OP_W-1:0] op);
        return (op >= OP_MULT) && (op <= OP_MSUBU);
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_hilo_move(input logic [OP_W-1:0] op);
        return (op >= OP_MTHI) && (op <= OP_MFLO);
    endfunction

endpackage

// File: rtl/md_op_fifo.sv
// In-order queue of pending mult/div ops; head is read straight from the storage registers.
module md_op_fifo
    import xalu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  md_op_t                   i_data,
    output md_op_t                   o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    md_op_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/xalu_dispatch.sv
// Issue stage feeding queued mult/div ops to the XALU, gated by a shadow occupancy counter
// so issue never waits on the XALU's own busy flag.
module xalu_dispatch
    import xalu_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned MUL_CYC = MUL_CYC_DEF,
    parameter int unsigned DIV_CYC = DIV_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_stall,
    output logic [3:0]  o_xalu_op,
    output logic [31:0] o_xalu_a,
    output logic [31:0] o_xalu_b,
    output logic        o_xalu_hi_we,
    output logic        o_xalu_lo_we,
    output logic [31:0] o_xalu_wdata,
    output logic        o_xalu_out_sel,
    input  logic        i_xalu_busy,
    output logic        o_rd_valid
);

    localparam int unsigned CNT_W = $clog2((DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC);
    localparam int unsigned QC_W  = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] r_cnt;
    md_op_t           w_head;
    md_op_t           w_push_data;
    logic             w_full;
    logic             w_empty;
    logic [QC_W-1:0]  w_count;
    logic             w_is_arith;
    logic             w_is_move;
    logic             w_accept;
    logic             w_push;
    logic             w_issue;

    assign w_is_arith  = is_arith(i_op);
    assign w_is_move   = is_hilo_move(i_op);
    assign w_push_data = '{op: i_op, a: i_a, b: i_b};

    // Moves must see HI/LO with every earlier op retired, so they wait for an empty, idle pipe.
    assign o_stall  = !reset && i_valid &&
                      ((w_is_arith && w_full) ||
                       (w_is_move && (!w_empty || (r_cnt != '0))));
    assign w_accept = !reset && i_valid && !o_stall;
    assign w_push   = w_accept && w_is_arith;
    assign w_issue  = !reset && !w_empty && (r_cnt == '0);

    md_op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_issue),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_issue) begin
            r_cnt <= is_div(w_head.op) ? CNT_W'(DIV_CYC - 1) : CNT_W'(MUL_CYC - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        o_xalu_op      = '0;
        o_xalu_a       = '0;
        o_xalu_b       = '0;
        o_xalu_hi_we   = 1'b0;
        o_xalu_lo_we   = 1'b0;
        o_xalu_wdata   = '0;
        o_xalu_out_sel = 1'b0;
        o_rd_valid     = 1'b0;
        if (w_issue) begin
            o_xalu_op = w_head.op;
            o_xalu_a  = w_head.a;
            o_xalu_b  = w_head.b;
        end
        if (w_accept && w_is_move) begin
            if ((i_op == OP_MTHI) || (i_op == OP_MTLO)) begin
                o_xalu_hi_we = (i_op == OP_MTHI);
                o_xalu_lo_we = (i_op == OP_MTLO);
                o_xalu_wdata = i_a;
            end else begin
                o_xalu_out_sel = (i_op == OP_MFLO);
                o_rd_valid     = 1'b1;
            end
        end
    end

    a_busy_when_counting: assert property (@(posedge clk) disable iff (reset)
        (r_cnt != '0) |-> i_xalu_busy);
    a_idle_when_quiet: assert property (@(posedge clk) disable iff (reset)
        ((r_cnt == '0) && (o_xalu_op == '0)) |-> !i_xalu_busy);
    a_issue_from_queue: assert property (@(posedge clk) disable iff (reset)
        (o_xalu_op != '0) |-> (w_count != '0));

endmodule

// File: tb/tb_xalu_dispatch.sv
// Directed bench for xalu_dispatch with a small behavioural XALU providing BUSY and HI/LO.
module tb_xalu_dispatch;
    import xalu_pkg::*;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic [3:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_stall;
    logic [3:0]  o_xalu_op;
    logic [31:0] o_xalu_a;
    logic [31:0] o_xalu_b;
    logic        o_xalu_hi_we;
    logic        o_xalu_lo_we;
    logic [31:0] o_xalu_wdata;
    logic        o_xalu_out_sel;
    logic        xalu_busy;
    logic        o_rd_valid;

    int n_cmp;
    int n_err;

    xalu_dispatch u_dut (
        .clk            (clk),
        .reset          (reset),
        .i_valid        (i_valid),
        .i_op           (i_op),
        .i_a            (i_a),
        .i_b            (i_b),
        .o_stall        (o_stall),
        .o_xalu_op      (o_xalu_op),
        .o_xalu_a       (o_xalu_a),
        .o_xalu_b       (o_xalu_b),
        .o_xalu_hi_we   (o_xalu_hi_we),
        .o_xalu_lo_we   (o_xalu_lo_we),
        .o_xalu_wdata   (o_xalu_wdata),
        .o_xalu_out_sel (o_xalu_out_sel),
        .i_xalu_busy    (xalu_busy),
        .o_rd_valid     (o_rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural XALU: result lands in HI/LO at the end of its last busy cycle.
    logic [31:0] x_hi;
    logic [31:0] x_lo;
    logic [63:0] x_pend;
    int          x_left;
    logic [31:0] xaluout;

    function automatic logic [63:0] xalu_calc(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] hilo);
        logic [63:0] r;
        case (op)
            OP_MULT:  r = 64'(longint'($signed(a)) * longint'($signed(b)));
            OP_MULTU: r = {32'd0, a} * {32'd0, b};
            OP_DIV:   r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            OP_DIVU:  r = {a % b, a / b};
            default:  r = hilo;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            x_hi   <= '0;
            x_lo   <= '0;
            x_pend <= '0;
            x_left <= 0;
        end else begin
            if (o_xalu_op != 4'd0) begin
                x_pend <= xalu_calc(o_xalu_op, o_xalu_a, o_xalu_b, {x_hi, x_lo});
                x_left <= is_div(o_xalu_op) ? 9 : 4;
            end else if (x_left != 0) begin
                x_left <= x_left - 1;
                if (x_left == 1) begin
                    x_hi <= x_pend[63:32];
                    x_lo <= x_pend[31:0];
                end
            end
            if (o_xalu_hi_we) x_hi <= o_xalu_wdata;
            if (o_xalu_lo_we) x_lo <= o_xalu_wdata;
        end
    end

    assign xalu_busy = (x_left != 0);
    assign xaluout   = o_xalu_out_sel ? x_lo : x_hi;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        i_valid = v;
        i_op    = op;
        i_a     = a;
        i_b     = b;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b1, OP_MULT, 32'd5, 32'd6);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (o_stall !== 1'b0) begin
                n_err++;
                $display("FAIL reset_stall c%0d: got %b expected 0", c, o_stall);
            end
            n_cmp++;
            if ({o_xalu_op, o_xalu_a, o_xalu_b, o_xalu_hi_we, o_xalu_lo_we, o_xalu_wdata,
                 o_xalu_out_sel, o_rd_valid} !== 104'd0) begin
                n_err++;
                $display("FAIL reset_outputs c%0d: got op=%h a=%h b=%h we=%b%b wd=%h sel=%b rv=%b expected all 0",
                         c, o_xalu_op, o_xalu_a, o_xalu_b, o_xalu_hi_we, o_xalu_lo_we,
                         o_xalu_wdata, o_xalu_out_sel, o_rd_valid);
            end
            next_cycle();
        end
        reset = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (o_xalu_op !== 4'd0) begin
                n_err++;
                $display("FAIL reset_not_queued c%0d: got op=%h expected 0", c, o_xalu_op);
            end
            next_cycle();
        end
    endtask

    task automatic test_mult_mflo;
        drive(1'b1, OP_MULT, 32'd3, 32'hFFFF_FFFC);
        #1;
        n_cmp++;
        if (o_stall !== 1'b0 || o_xalu_op !== 4'd0) begin
            n_err++;
            $display("FAIL mult_accept c0: got stall=%b op=%h expected stall=0 op=0", o_stall, o_xalu_op);
        end
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        #1;
        n_cmp++;
        if (o_xalu_op !== 4'd1 || o_xalu_a !== 32'd3 || o_xalu_b !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL mult_issue c1: got op=%h a=%h b=%h expected op=1 a=3 b=fffffffc",
                     o_xalu_op, o_xalu_a, o_xalu_b);
        end
        next_cycle();
        drive(1'b1, OP_MFLO, 32'd0, 32'd0);
        for (int c = 2; c < 6; c++) begin
            #1;
            n_cmp++;
            if (o_stall !== 1'b1 || o_rd_valid !== 1'b0 || o_xalu_op !== 4'd0) begin
                n_err++;
                $display("FAIL mflo_wait c%0d: got stall=%b rv=%b op=%h expected stall=1 rv=0 op=0",
                         c, o_stall, o_rd_valid, o_xalu_op);
            end
            next_cycle();
        end
        #1;
        n_cmp++;
        if (o_stall !== 1'b0 || o_rd_valid !== 1'b1 || o_xalu_out_sel !== 1'b1 || xaluout !== 32'hFFFF_FFF4) begin
            n_err++;
            $display("FAIL mflo_read c6: got stall=%b rv=%b sel=%b out=%h expected stall=0 rv=1 sel=1 out=fffffff4",
                     o_stall, o_rd_valid, o_xalu_out_sel, xaluout);
        end
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_op;
        for (int c = 0; c < 32; c++) begin
            if (c == 0)       drive(1'b1, OP_DIV,   32'd100, 32'd7);
            else if (c == 1)  drive(1'b1, OP_DIVU,  32'd50,  32'd5);
            else if (c == 2)  drive(1'b1, OP_MULT,  32'd6,   32'd7);
            else if (c <= 12) drive(1'b1, OP_MULTU, 32'd2,   32'd3);
            else if (c == 31) drive(1'b1, OP_MFLO,  32'd0,   32'd0);
            else              drive(1'b0, 4'd0,     32'd0,   32'd0);
            #1;
            exp_op = 4'd0;
            if (c == 1)  exp_op = OP_DIV;
            if (c == 11) exp_op = OP_DIVU;
            if (c == 21) exp_op = OP_MULT;
            if (c == 26) exp_op = OP_MULTU;
            n_cmp++;
            if (o_xalu_op !== exp_op) begin
                n_err++;
                $display("FAIL b2b_issue c%0d: got op=%h expected %h", c, o_xalu_op, exp_op);
            end
            if (c <= 2 || c == 12 || c == 31) begin
                n_cmp++;
                if (o_stall !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_accept c%0d: got stall=%b expected 0", c, o_stall);
                end
            end else if (c >= 4 && c <= 11) begin
                n_cmp++;
                if (o_stall !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_full_stall c%0d: got stall=%b expected 1", c, o_stall);
                end
            end
            if (c == 31) begin
                n_cmp++;
                if (o_rd_valid !== 1'b1 || xaluout !== 32'd6) begin
                    n_err++;
                    $display("FAIL b2b_result c31: got rv=%b out=%h expected rv=1 out=6", o_rd_valid, xaluout);
                end
            end
            next_cycle();
        end
        drive(1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic test_mthi_mfhi;
        drive(1'b1, OP_MTHI, 32'h1234, 32'd0);
        #1;
        n_cmp++;
        if (o_stall !== 1'b0 || o_xalu_hi_we !== 1'b1 || o_xalu_lo_we !== 1'b0 || o_xalu_wdata !== 32'h1234) begin
            n_err++;
            $display("FAIL mthi c0: got stall=%b hi_we=%b lo_we=%b wd=%h expected 0 1 0 1234",
                     o_stall, o_xalu_hi_we, o_xalu_lo_we, o_xalu_wdata);
        end
        next_cycle();
        drive(1'b1, OP_MFHI, 32'd0, 32'd0);
        #1;
        n_cmp++;
        if (o_rd_valid !== 1'b1 || o_xalu_out_sel !== 1'b0 || xaluout !== 32'h1234 || o_xalu_hi_we !== 1'b0) begin
            n_err++;
            $display("FAIL mfhi c1: got rv=%b sel=%b out=%h hi_we=%b expected 1 0 1234 0",
                     o_rd_valid, o_xalu_out_sel, xaluout, o_xalu_hi_we);
        end
        next_cycle();
        drive(1'b0, OP_MTHI, 32'h5555, 32'd0);
        #1;
        n_cmp++;
        if (o_xalu_hi_we !== 1'b0 || o_xalu_wdata !== 32'd0 || o_rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL move_idle c2: got hi_we=%b wd=%h rv=%b expected 0 0 0",
                     o_xalu_hi_we, o_xalu_wdata, o_rd_valid);
        end
        next_cycle();
    endtask

    task automatic test_mtlo_stall;
        drive(1'b1, OP_MULT, 32'd7, 32'd9);
        next_cycle();
        drive(1'b1, OP_MTLO, 32'hABCD, 32'd0);
        for (int c = 1; c < 6; c++) begin
            #1;
            n_cmp++;
            if (o_stall !== 1'b1 || o_xalu_lo_we !== 1'b0) begin
                n_err++;
                $display("FAIL mtlo_wait c%0d: got stall=%b lo_we=%b expected 1 0", c, o_stall, o_xalu_lo_we);
            end
            next_cycle();
        end
        #1;
        n_cmp++;
        if (o_stall !== 1'b0 || o_xalu_lo_we !== 1'b1 || o_xalu_wdata !== 32'hABCD) begin
            n_err++;
            $display("FAIL mtlo_write c6: got stall=%b lo_we=%b wd=%h expected 0 1 abcd",
                     o_stall, o_xalu_lo_we, o_xalu_wdata);
        end
        next_cycle();
        drive(1'b1, OP_MFLO, 32'd0, 32'd0);
        #1;
        n_cmp++;
        if (o_xalu_lo_we !== 1'b0 || o_rd_valid !== 1'b1 || xaluout !== 32'hABCD) begin
            n_err++;
            $display("FAIL mtlo_final c7: got lo_we=%b rv=%b out=%h expected 0 1 abcd",
                     o_xalu_lo_we, o_rd_valid, xaluout);
        end
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic test_reset_mid_op;
        drive(1'b1, OP_DIV, 32'd1000, 32'd3);
        next_cycle();
        drive(1'b1, OP_MULT, 32'd1, 32'd1);
        #1;
        n_cmp++;
        if (o_stall !== 1'b0 || o_xalu_op !== OP_DIV) begin
            n_err++;
            $display("FAIL rmid_issue c1: got stall=%b op=%h expected 0 3", o_stall, o_xalu_op);
        end
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        repeat (3) next_cycle();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (o_stall !== 1'b0 || o_xalu_op !== 4'd0) begin
            n_err++;
            $display("FAIL rmid_in_reset c5: got stall=%b op=%h expected 0 0", o_stall, o_xalu_op);
        end
        next_cycle();
        reset = 1'b0;
        drive(1'b1, OP_MFHI, 32'd0, 32'd0);
        #1;
        n_cmp++;
        if (o_stall !== 1'b0 || o_rd_valid !== 1'b1 || xaluout !== 32'd0) begin
            n_err++;
            $display("FAIL rmid_mfhi c6: got stall=%b rv=%b out=%h expected 0 1 0", o_stall, o_rd_valid, xaluout);
        end
        next_cycle();
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        for (int c = 7; c < 15; c++) begin
            #1;
            n_cmp++;
            if (o_xalu_op !== 4'd0) begin
                n_err++;
                $display("FAIL rmid_dropped c%0d: got op=%h expected 0", c, o_xalu_op);
            end
            next_cycle();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        next_cycle();
        test_reset();
        test_mult_mflo();
        test_back_to_back();
        test_mthi_mfhi();
        test_mtlo_stall();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
